// File: rtl/mole_hit_scorer.sv
// Whack-a-mole scorer: turns whack strikes and mole up/down windows into
// hit, miss and escape events, keeps per-game counters and a high score.
//
// Ports:
//   clk, rst           - system clock, asynchronous active-high reset
//   game_in_progress   - high while a game runs
//   mole_clk           - high = mole-up window, low = mole-down window
//   whack_button       - player strike (level, synchronous to clk)
//   mole_visible       - high while a hittable mole is up
//   hit_pulse, miss_pulse, escape_pulse, game_over_pulse - one-cycle strobes
//   score, misses, escapes, high_score - saturating SCORE_W-bit counters
module mole_hit_scorer #(
    parameter int unsigned SCORE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_in_progress,
    input  logic               mole_clk,
    input  logic               whack_button,
    output logic               mole_visible,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               escape_pulse,
    output logic               game_over_pulse,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic [SCORE_W-1:0] escapes,
    output logic [SCORE_W-1:0] high_score
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        UP   = 2'd2,
        HIT  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               whack_q, mole_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] misses_q, misses_d;
    logic [SCORE_W-1:0] escapes_q, escapes_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic               vis_q, vis_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               esc_q, esc_d;
    logic               go_q, go_d;

    logic whack_edge, mole_rise, mole_fall;

    assign whack_edge = whack_button & ~whack_q;
    assign mole_rise  = mole_clk & ~mole_q;
    assign mole_fall  = ~mole_clk & mole_q;

    // Counters stick at all-ones; the event pulse still fires.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
    endfunction

    // Next-state, counter and pulse logic.
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        misses_d  = misses_q;
        escapes_d = escapes_q;
        high_d    = high_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        esc_d     = 1'b0;
        go_d      = 1'b0;

        if (state_q == IDLE) begin
            if (game_in_progress) begin
                score_d   = '0;
                misses_d  = '0;
                escapes_d = '0;
                state_d   = DOWN;
            end
        end else if (!game_in_progress) begin
            // Game end overrides any same-cycle event.
            state_d = IDLE;
            go_d    = 1'b1;
            if (score_q > high_q) begin
                high_d = score_q;
            end
        end else begin
            unique case (state_q)
                DOWN: begin
                    if (mole_rise) begin
                        state_d = UP;
                    end
                    // A whack while mole_clk is already high is a stale window; ignore it.
                    if (whack_edge && !mole_clk) begin
                        misses_d = sat_inc(misses_q);
                        miss_d   = 1'b1;
                    end
                end
                UP: begin
                    if (whack_edge) begin
                        score_d = sat_inc(score_q);
                        hit_d   = 1'b1;
                        state_d = mole_fall ? DOWN : HIT;
                    end else if (mole_fall) begin
                        escapes_d = sat_inc(escapes_q);
                        esc_d     = 1'b1;
                        state_d   = DOWN;
                    end
                end
                HIT: begin
                    if (mole_fall) begin
                        state_d = DOWN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        vis_d = (state_d == UP);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            whack_q   <= 1'b0;
            mole_q    <= 1'b0;
            score_q   <= '0;
            misses_q  <= '0;
            escapes_q <= '0;
            high_q    <= '0;
            vis_q     <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            esc_q     <= 1'b0;
            go_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            whack_q   <= whack_button;
            mole_q    <= mole_clk;
            score_q   <= score_d;
            misses_q  <= misses_d;
            escapes_q <= escapes_d;
            high_q    <= high_d;
            vis_q     <= vis_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            esc_q     <= esc_d;
            go_q      <= go_d;
        end
    end

    assign mole_visible    = vis_q;
    assign hit_pulse       = hit_q;
    assign miss_pulse      = miss_q;
    assign escape_pulse    = esc_q;
    assign game_over_pulse = go_q;
    assign score           = score_q;
    assign misses          = misses_q;
    assign escapes         = escapes_q;
    assign high_score      = high_q;

endmodule

// File: tb/tb_mole_hit_scorer.sv
// Directed bench for mole_hit_scorer: a table of per-cycle vectors on the
// default-width instance plus hand-written saturation / async reset sequences
// (a 2-bit instance shares the same stimulus for the saturation check).
module tb_mole_hit_scorer;

    logic clk, rst, gip, mole, whack;

    logic       vis8, hit8, miss8, esc8, go8;
    logic [7:0] sc8, mi8, es8, hi8;
    logic       vis2, hit2, miss2, esc2, go2;
    logic [1:0] sc2, mi2, es2, hi2;

    int n_checks = 0;
    int n_fail   = 0;

    mole_hit_scorer #(.SCORE_W(8)) dut8 (
        .clk(clk), .rst(rst), .game_in_progress(gip), .mole_clk(mole),
        .whack_button(whack), .mole_visible(vis8), .hit_pulse(hit8),
        .miss_pulse(miss8), .escape_pulse(esc8), .game_over_pulse(go8),
        .score(sc8), .misses(mi8), .escapes(es8), .high_score(hi8)
    );

    mole_hit_scorer #(.SCORE_W(2)) dut2 (
        .clk(clk), .rst(rst), .game_in_progress(gip), .mole_clk(mole),
        .whack_button(whack), .mole_visible(vis2), .hit_pulse(hit2),
        .miss_pulse(miss2), .escape_pulse(esc2), .game_over_pulse(go2),
        .score(sc2), .misses(mi2), .escapes(es2), .high_score(hi2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       gip, mole, whack;
        logic       vis, hit, miss, esc, go;
        logic [7:0] sc, mi, es, hi;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic g, m, w, v, h, ms, e, o,
                                input int s, mm, ee, hh);
        vec_t r;
        r.gip = g; r.mole = m; r.whack = w;
        r.vis = v; r.hit = h; r.miss = ms; r.esc = e; r.go = o;
        r.sc = 8'(s); r.mi = 8'(mm); r.es = 8'(ee); r.hi = 8'(hh);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic g, input logic m, input logic w);
        gip = g; mole = m; whack = w;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [36:0] pack8();
        return {vis8, hit8, miss8, esc8, go8, sc8, mi8, es8, hi8};
    endfunction

    int hits2;

    initial begin
        //             g m w  v h m e o  sc mi es hi
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 0,0,0,0)); // 0 start game
        vecs.push_back(mk(1,1,0, 1,0,0,0,0, 0,0,0,0)); // 1 mole up
        vecs.push_back(mk(1,1,1, 0,1,0,0,0, 1,0,0,0)); // 2 hit
        vecs.push_back(mk(1,1,0, 0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,0, 1,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,1, 0,1,0,0,0, 2,0,0,0)); // 6 hit
        vecs.push_back(mk(1,0,1, 0,0,0,0,0, 2,0,0,0)); // 7 held whack
        vecs.push_back(mk(1,1,0, 1,0,0,0,0, 2,0,0,0));
        vecs.push_back(mk(1,1,1, 0,1,0,0,0, 3,0,0,0)); // 9 hit
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 3,0,0,0));
        vecs.push_back(mk(1,1,0, 1,0,0,0,0, 3,0,0,0));
        vecs.push_back(mk(1,1,1, 0,1,0,0,0, 4,0,0,0)); // 12 hit
        vecs.push_back(mk(1,1,0, 0,0,0,0,0, 4,0,0,0));
        vecs.push_back(mk(1,1,1, 0,0,0,0,0, 4,0,0,0)); // 14 second whack ignored
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 4,0,0,0));
        vecs.push_back(mk(1,0,1, 0,0,1,0,0, 4,1,0,0)); // 16 miss
        vecs.push_back(mk(1,0,1, 0,0,0,0,0, 4,1,0,0)); // 17 held, no repeat
        vecs.push_back(mk(1,1,0, 1,0,0,0,0, 4,1,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,1,0, 4,1,1,0)); // 19 escape
        vecs.push_back(mk(1,1,0, 1,0,0,0,0, 4,1,1,0));
        vecs.push_back(mk(1,0,1, 0,1,0,0,0, 5,1,1,0)); // 21 whack with fall
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 5,1,1,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,1, 5,1,1,5)); // 23 game over
        vecs.push_back(mk(0,1,1, 0,0,0,0,0, 5,1,1,5)); // 24 idle holds
        vecs.push_back(mk(1,1,0, 0,0,0,0,0, 0,0,0,5)); // 25 game 2 start
        vecs.push_back(mk(1,1,1, 0,0,0,0,0, 0,0,0,5)); // 26 stale window
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 0,0,0,5));
        vecs.push_back(mk(1,1,0, 1,0,0,0,0, 0,0,0,5));
        vecs.push_back(mk(1,1,1, 0,1,0,0,0, 1,0,0,5));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 1,0,0,5));
        vecs.push_back(mk(1,1,0, 1,0,0,0,0, 1,0,0,5));
        vecs.push_back(mk(1,1,1, 0,1,0,0,0, 2,0,0,5));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 2,0,0,5));
        vecs.push_back(mk(1,1,0, 1,0,0,0,0, 2,0,0,5));
        vecs.push_back(mk(1,1,1, 0,1,0,0,0, 3,0,0,5));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 3,0,0,5));
        vecs.push_back(mk(0,0,0, 0,0,0,0,1, 3,0,0,5)); // 37 game over, high kept
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 0,0,0,5));
        vecs.push_back(mk(1,1,0, 1,0,0,0,0, 0,0,0,5));
        vecs.push_back(mk(0,1,1, 0,0,0,0,1, 0,0,0,5)); // 40 end beats hit

        rst = 1'b1; gip = 1'b0; mole = 1'b0; whack = 1'b0;
        #12;
        check("reset_state8", 64'(pack8()), 64'd0);
        check("reset_state2", 64'({vis2, hit2, miss2, esc2, go2, sc2, mi2, es2, hi2}), 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].gip, vecs[i].mole, vecs[i].whack);
            check($sformatf("vec%0d", i), 64'(pack8()),
                  64'({vecs[i].vis, vecs[i].hit, vecs[i].miss, vecs[i].esc, vecs[i].go,
                       vecs[i].sc, vecs[i].mi, vecs[i].es, vecs[i].hi}));
        end

        // Saturation: five hits on the 2-bit instance.
        hits2 = 0;
        step(1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 0);
            step(1, 1, 1);
            if (hit2) hits2++;
            step(1, 0, 0);
        end
        check("sat_score2", 64'(sc2), 64'd3);
        check("sat_hits2", 64'(hits2), 64'd5);
        check("sat_score8", 64'(sc8), 64'd5);

        // Async reset in the middle of an up window.
        step(1, 1, 0);
        check("up_visible", 64'(vis8), 64'd1);
        whack = 1'b1;
        rst = 1'b1;
        #1;
        check("async_rst8", 64'(pack8()), 64'd0);
        check("async_rst2", 64'({vis2, hit2, miss2, esc2, go2, sc2, mi2, es2, hi2}), 64'd0);
        #2;
        rst = 1'b0;

        // Whack held across reset release: its edge lands in IDLE and is dropped.
        step(0, 0, 1);
        check("held_idle", 64'(pack8()), 64'd0);
        step(1, 0, 1);
        step(1, 0, 1);
        check("held_no_miss", 64'(mi8), 64'd0);
        step(1, 0, 0);
        step(1, 0, 1);
        check("fresh_miss", 64'({miss8, mi8}), 64'({1'b1, 8'd1}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
